// File: rtl/mult_err_pkg.sv
// Shared definitions for the multiplier error sweep.
// Holds the FSM state enum, the sweep length and the datapath widths,
// plus a small absolute-difference helper used by the error stage.
package mult_err_pkg;

    localparam int A_W     = 4;    // operand width of the multiplier under test
    localparam int P_W     = 8;    // product / error-distance width
    localparam int CNT_W   = 9;    // err_cnt width, holds 0..256
    localparam int SUM_W   = 16;   // err_sum width, holds up to 256*255
    localparam int N_PAIRS = 256;  // every (a, b) pair of two 4-bit operands

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [P_W-1:0] abs_diff(input logic [P_W-1:0] x,
                                                input logic [P_W-1:0] y);
        return (x >= y) ? (x - y) : (y - x);
    endfunction

endpackage

// File: rtl/mult_err_sweep_if.sv
// Operand/product bus between the sweep controller and the multiplier
// under test.
//   op_a, op_b : operands driven by the sweep controller
//   approx_p   : product returned combinationally by the multiplier
// master = sweep controller, slave = multiplier under test.
interface mult_err_sweep_if;
    import mult_err_pkg::*;

    logic [A_W-1:0] op_a;
    logic [A_W-1:0] op_b;
    logic [P_W-1:0] approx_p;

    modport master (output op_a, output op_b, input approx_p);
    modport slave  (input op_a, input op_b, output approx_p);

endinterface

// File: rtl/mult_err_sweep.sv
// Exhaustive error sweep of an approximate 4x4 multiplier.
// Walks all 256 operand pairs, compares the returned product against the
// exact product and accumulates error count, error sum and maximum error.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : begin a sweep (accepted in IDLE or DONE)
//   clear          : synchronous abort, returns to IDLE with results zeroed
//   mul (master)   : op_a/op_b out, approx_p in
//   busy, done     : busy in SWEEP/DRAIN, done in DONE
//   err_cnt        : pairs whose error distance exceeds ERR_THRESH
//   err_sum        : sum of error distances
//   max_err        : largest error distance
//
// state | meaning
// IDLE  | waiting for start, results held
// SWEEP | driving pair idx, one pair per cycle
// DRAIN | last captured error is being accumulated
// DONE  | results valid and stable, start begins a new sweep
module mult_err_sweep
    import mult_err_pkg::*;
#(
    parameter logic [P_W-1:0] ERR_THRESH = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               clear,
    mult_err_sweep_if.master   mul,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   err_cnt,
    output logic [SUM_W-1:0]   err_sum,
    output logic [P_W-1:0]     max_err
);

    state_t         state;
    state_t         state_nxt;
    logic [P_W-1:0] idx;
    logic [A_W-1:0] op_a_i;
    logic [A_W-1:0] op_b_i;
    logic [P_W-1:0] exact_p;
    logic [P_W-1:0] s1_err;
    logic           s1_valid;
    logic           start_ok;
    logic           last_pair;

    assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign last_pair = (state == ST_SWEEP) && (idx == P_W'(N_PAIRS - 1));

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (start)     state_nxt = ST_SWEEP;
                ST_SWEEP: if (last_pair) state_nxt = ST_DRAIN;
                ST_DRAIN:                state_nxt = ST_DONE;
                ST_DONE:  if (start)     state_nxt = ST_SWEEP;
                default:                 state_nxt = ST_IDLE;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        op_a_i = '0;
        op_b_i = '0;
        case (state)
            ST_SWEEP: begin
                busy   = 1'b1;
                op_a_i = idx[P_W-1:A_W];
                op_b_i = idx[A_W-1:0];
            end
            ST_DRAIN: busy = 1'b1;
            ST_DONE:  done = 1'b1;
            default:  ;
        endcase
    end

    assign mul.op_a = op_a_i;
    assign mul.op_b = op_b_i;

    // Zero-extend before multiplying so the exact product is a full 8 bits.
    assign exact_p = {{(P_W-A_W){1'b0}}, op_a_i} * {{(P_W-A_W){1'b0}}, op_b_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (clear || start_ok) begin
            idx <= '0;
        end else if (state == ST_SWEEP) begin
            idx <= idx + 1'b1;
        end
    end

    // Stage 1: capture the error distance of the pair currently on the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_err   <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_err   <= abs_diff(exact_p, mul.approx_p);
            s1_valid <= !clear && (state == ST_SWEEP);
        end
    end

    // Stage 2: accumulate. Accepting start clears the previous results so
    // a sweep launched from DONE begins from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
            err_sum <= '0;
            max_err <= '0;
        end else if (clear || start_ok) begin
            err_cnt <= '0;
            err_sum <= '0;
            max_err <= '0;
        end else if (s1_valid) begin
            err_sum <= err_sum + SUM_W'(s1_err);
            if (s1_err > ERR_THRESH) err_cnt <= err_cnt + 1'b1;
            if (s1_err > max_err)    max_err <= s1_err;
        end
    end

endmodule

// File: tb/tb_mult_err_sweep.sv
// Self-checking bench for mult_err_sweep. Two instances run in lockstep,
// one with ERR_THRESH=0 and one with ERR_THRESH=100, both fed by a
// bench-side multiplier model selected by 'mode'. The reference is the
// expected result after the first c pairs, built from plain arithmetic,
// together with the count of clock edges since the accepted start.
module tb_mult_err_sweep;
    import mult_err_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic clear = 1'b0;

    logic       busy0, done0, busy1, done1;
    logic [8:0] cnt0, cnt1;
    logic [15:0] sum0, sum1;
    logic [7:0] mx0, mx1;

    int        mode = 0;          // 0 exact, 1 zero, 2 all-ones, 3 random table
    logic [7:0] rnd_tab [256];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int e0_cyc   = 0;
    int m_n      = -1;            // edges since accepted start, -1 = idle/zeroed
    bit chk_en   = 1'b1;

    int thr [2] = '{0, 100};
    int e_cnt [2][257];
    int e_sum [2][257];
    int e_max [2][257];

    mult_err_sweep_if bus0 ();
    mult_err_sweep_if bus1 ();

    assign bus0.approx_p = (mode == 0) ? (8'(bus0.op_a) * 8'(bus0.op_b)) :
                           (mode == 1) ? 8'h00 :
                           (mode == 2) ? 8'hFF : rnd_tab[{bus0.op_a, bus0.op_b}];
    assign bus1.approx_p = (mode == 0) ? (8'(bus1.op_a) * 8'(bus1.op_b)) :
                           (mode == 1) ? 8'h00 :
                           (mode == 2) ? 8'hFF : rnd_tab[{bus1.op_a, bus1.op_b}];

    mult_err_sweep #(.ERR_THRESH(8'd0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .mul(bus0),
        .busy(busy0), .done(done0), .err_cnt(cnt0), .err_sum(sum0), .max_err(mx0)
    );

    mult_err_sweep #(.ERR_THRESH(8'd100)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .mul(bus1),
        .busy(busy1), .done(done1), .err_cnt(cnt1), .err_sum(sum1), .max_err(mx1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Reference sweep progress.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                  m_n = -1;
        else if (clear)                              m_n = -1;
        else if (start && (m_n < 0 || m_n >= 257))   m_n = 0;
        else if (m_n >= 0 && m_n < 257)              m_n = m_n + 1;
    end

    function automatic int approx_of(input int a, input int b);
        case (mode)
            0:       return a * b;
            1:       return 0;
            2:       return 255;
            default: return int'(rnd_tab[a*16 + b]);
        endcase
    endfunction

    task automatic compute_model();
        for (int t = 0; t < 2; t++) begin
            e_cnt[t][0] = 0; e_sum[t][0] = 0; e_max[t][0] = 0;
            for (int k = 0; k < 256; k++) begin
                int e;
                e = (k / 16) * (k % 16) - approx_of(k / 16, k % 16);
                if (e < 0) e = -e;
                e_cnt[t][k+1] = e_cnt[t][k] + ((e > thr[t]) ? 1 : 0);
                e_sum[t][k+1] = e_sum[t][k] + e;
                e_max[t][k+1] = (e > e_max[t][k]) ? e : e_max[t][k];
            end
        end
    endtask

    task automatic check(input string name, input int d, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0d expected %0d (t=%0t)", name, d, act, exp, $time);
        end
    endtask

    task automatic cmp_dut(input int d, input logic bz, input logic dn,
                           input logic [3:0] a, input logic [3:0] b,
                           input logic [8:0] cnt, input logic [15:0] sum,
                           input logic [7:0] mx);
        int n, c, ea, eb;
        logic ebz, edn;
        n = m_n;
        ebz = 1'b0; edn = 1'b0; ea = 0; eb = 0; c = 0;
        if (n >= 0) begin
            ebz = (n <= 256);
            edn = (n >= 257);
            if (n <= 255) begin ea = n / 16; eb = n % 16; end
            c = n - 1;
            if (c < 0)   c = 0;
            if (c > 256) c = 256;
        end
        check("busy",    d, bz,  ebz);
        check("done",    d, dn,  edn);
        check("op_a",    d, a,   ea);
        check("op_b",    d, b,   eb);
        check("err_cnt", d, cnt, e_cnt[d][c]);
        check("err_sum", d, sum, e_sum[d][c]);
        check("max_err", d, mx,  e_max[d][c]);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_dut(0, busy0, done0, bus0.op_a, bus0.op_b, cnt0, sum0, mx0);
            cmp_dut(1, busy1, done1, bus1.op_a, bus1.op_b, cnt1, sum1, mx1);
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 0, busy0, 0);  check({tag, "_busy"}, 1, busy1, 0);
        check({tag, "_done"}, 0, done0, 0);  check({tag, "_done"}, 1, done1, 0);
        check({tag, "_op"},   0, {bus0.op_a, bus0.op_b}, 0);
        check({tag, "_op"},   1, {bus1.op_a, bus1.op_b}, 0);
        check({tag, "_cnt"},  0, cnt0, 0);   check({tag, "_cnt"},  1, cnt1, 0);
        check({tag, "_sum"},  0, sum0, 0);   check({tag, "_sum"},  1, sum1, 0);
        check({tag, "_max"},  0, mx0, 0);    check({tag, "_max"},  1, mx1, 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e0_cyc = cyc;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic wait_done();
        int i;
        for (i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done0) break;
        end
        check("done_seen", 0, done0, 1);
        check("done_latency", 0, cyc - e0_cyc, 257);
    endtask

    task automatic pin(input int d, input int c, input int s, input int m);
        if (d == 0) begin
            check("pin_cnt", 0, cnt0, c); check("pin_sum", 0, sum0, s); check("pin_max", 0, mx0, m);
        end else begin
            check("pin_cnt", 1, cnt1, c); check("pin_sum", 1, sum1, s); check("pin_max", 1, mx1, m);
        end
    endtask

    initial begin
        int c100;
        logic [8:0]  r_cnt0, r_cnt1;
        logic [15:0] r_sum0, r_sum1;
        logic [7:0]  r_mx0, r_mx1;

        for (int i = 0; i < 256; i++) rnd_tab[i] = 8'($urandom_range(0, 255));
        compute_model();

        #1 rst_n = 1'b0;
        #1 check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // exact multiplier: no error at all
        mode = 0; compute_model();
        pulse_start(); wait_done();
        pin(0, 0, 0, 0); pin(1, 0, 0, 0);
        repeat (3) @(negedge clk);

        // product tied to zero
        do_clear(); check_all_zero("clear");
        mode = 1; compute_model();
        pulse_start(); wait_done();
        pin(0, 225, 14400, 225);
        c100 = 0;
        for (int a = 0; a < 16; a++) for (int b = 0; b < 16; b++) if (a * b > 100) c100++;
        pin(1, c100, 14400, 225);

        // product tied to all ones
        do_clear();
        mode = 2; compute_model();
        pulse_start(); wait_done();
        pin(0, 256, 50880, 255);
        c100 = 0;
        for (int a = 0; a < 16; a++) for (int b = 0; b < 16; b++) if (255 - a * b > 100) c100++;
        pin(1, c100, 50880, 255);

        // random table, back-to-back sweeps
        do_clear();
        mode = 3; compute_model();
        pulse_start(); wait_done();
        r_cnt0 = cnt0; r_sum0 = sum0; r_mx0 = mx0;
        r_cnt1 = cnt1; r_sum1 = sum1; r_mx1 = mx1;
        repeat (2) @(negedge clk);
        pulse_start();
        check("b2b_clear_cnt", 0, cnt0, 0);
        check("b2b_clear_sum", 0, sum0, 0);
        check("b2b_busy", 0, busy0, 1);
        wait_done();
        pin(0, r_cnt0, r_sum0, r_mx0);
        pin(1, r_cnt1, r_sum1, r_mx1);

        // start while busy is ignored
        repeat (2) @(negedge clk);
        pulse_start();
        repeat (50) @(negedge clk);
        check("op_at_50", 0, {bus0.op_a, bus0.op_b}, 50);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("still_busy", 0, busy0, 1);
        for (int i = 0; i < 400; i++) begin
            if (done0) break;
            @(negedge clk);
        end
        check("ignore_done_latency", 0, cyc - e0_cyc, 257);

        // clear mid-sweep
        repeat (2) @(negedge clk);
        pulse_start();
        repeat (100) @(negedge clk);
        check("op_at_100", 0, {bus0.op_a, bus0.op_b}, 100);
        do_clear();
        check_all_zero("abort");

        // reset mid-sweep, then a full sweep after release
        pulse_start();
        repeat (80) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_after_rst", 0, busy0, 0);
        pulse_start(); wait_done();
        pin(0, r_cnt0, r_sum0, r_mx0);
        pin(1, r_cnt1, r_sum1, r_mx1);

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
